// File: rtl/regena_pkg.sv
`timescale 1ns/1ps
// regena_pkg
// Shared definitions for the regena_loader serial word loader:
//   state_t      FSM state encoding (binary: IDLE=0, SHIFT=1, PAR=2)
//   REGENA_W     default data word width
//   cnt_width()  bit-counter width for a given word width, clog2(WIDTH+1)
package regena_pkg;

   localparam int REGENA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2
   } state_t;

   // The counter must be able to hold WIDTH itself, since it reaches WIDTH
   // while the parity bit is pending.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/regena_loader_shreg.sv
`timescale 1ns/1ps
// regena_loader_shreg
// Shift register, bit counter and running data parity for regena_loader.
// Ports:
//   clock, reset      clock and asynchronous active-low reset
//   start             load din as bit 1 of a new frame (count=1)
//   shift             shift din into the word, count+1
//   clear             return count and parity to 0 (overrides shift's count)
//   din               serial data bit
//   word              assembled shift register contents
//   word_next         word as it will look after this cycle's shift/start
//   count             number of data bits held
//   parity            XOR of the data bits held
module regena_loader_shreg
   import regena_pkg::*;
#(
   parameter int WIDTH     = REGENA_W,
   parameter int MSB_FIRST = 1,
   parameter int CW        = cnt_width(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             shift,
   input  logic             clear,
   input  logic             din,
   output logic [WIDTH-1:0] word,
   output logic [WIDTH-1:0] word_next,
   output logic [CW-1:0]    count,
   output logic             parity
);

   // A new frame shifts into an all-zero register so the stale partial word
   // never leaks into the next one.
   logic [WIDTH-1:0] base;

   always_comb begin
      base = start ? '0 : word;
      if (MSB_FIRST != 0) word_next = {base[WIDTH-2:0], din};
      else                word_next = {din, base[WIDTH-1:1]};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word   <= '0;
         count  <= '0;
         parity <= 1'b0;
      end else if (start) begin
         word   <= word_next;
         count  <= CW'(1);
         parity <= din;
      end else begin
         if (shift) word <= word_next;
         if (clear) begin
            count  <= '0;
            parity <= 1'b0;
         end else if (shift) begin
            count  <= count + CW'(1);
            parity <= parity ^ din;
         end
      end
   end

endmodule

// File: rtl/regena_loader.sv
`timescale 1ns/1ps
// regena_loader
// Deserialises a framed serial bit stream into WIDTH-bit words for the
// enabled holding register, strobing ena for one cycle per good word and
// pulsing frame_err on premature start-of-frame (or parity mismatch).
// Optional feature macro: REGENA_LOADER_PARITY_EN adds an even-parity bit
// after the WIDTH data bits (PAR state).
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   sin_valid  serial bit qualifier
//   sin_data   serial data bit
//   sin_sof    start-of-frame marker (meaningful only with sin_valid)
//   R          last complete word (registered)
//   ena        one-cycle load strobe, cycle after the final bit
//   busy       frame in progress (registered)
//   frame_err  one-cycle error pulse
//   dbg_state  current FSM state
// Handshake: a bit is transferred on every rising edge where sin_valid=1;
// there is no back-pressure, the loader accepts every valid bit.
module regena_loader
   import regena_pkg::*;
#(
   parameter int WIDTH     = REGENA_W,
   parameter int MSB_FIRST = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sin_valid,
   input  logic             sin_data,
   input  logic             sin_sof,
   output logic [WIDTH-1:0] R,
   output logic             ena,
   output logic             busy,
   output logic             frame_err,
   output logic [1:0]       dbg_state
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic             sr_start, sr_shift, sr_clear;
   logic [WIDTH-1:0] word, word_next;
   logic [CW-1:0]    count;
   logic             parity;
   logic             last_bit;

   // True when the bit currently offered would be data bit number WIDTH.
   assign last_bit  = (count == CW'(WIDTH - 1));
   assign dbg_state = state;

   always_comb begin
      sr_start = 1'b0;
      sr_shift = 1'b0;
      sr_clear = 1'b0;
      if (sin_valid) begin
         case (state)
            ST_IDLE:  sr_start = sin_sof;
            ST_SHIFT: begin
               if (sin_sof) sr_start = 1'b1;
               else begin
                  sr_shift = 1'b1;
`ifndef REGENA_LOADER_PARITY_EN
                  sr_clear = last_bit;
`endif
               end
            end
`ifdef REGENA_LOADER_PARITY_EN
            ST_PAR: begin
               // The parity bit itself is never shifted into the word.
               if (sin_sof) sr_start = 1'b1;
               else         sr_clear = 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

   regena_loader_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .CW        (CW)
   ) u_shreg (
      .clock     (clock),
      .reset     (reset),
      .start     (sr_start),
      .shift     (sr_shift),
      .clear     (sr_clear),
      .din       (sin_data),
      .word      (word),
      .word_next (word_next),
      .count     (count),
      .parity    (parity)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         R         <= '0;
         ena       <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         ena       <= 1'b0;
         frame_err <= 1'b0;
         if (sin_valid) begin
            case (state)
               ST_IDLE: begin
                  if (sin_sof) begin
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                  end
               end
               ST_SHIFT: begin
                  if (sin_sof) begin
                     frame_err <= 1'b1;
                  end else if (last_bit) begin
`ifdef REGENA_LOADER_PARITY_EN
                     state <= ST_PAR;
`else
                     R     <= word_next;
                     ena   <= 1'b1;
                     state <= ST_IDLE;
                     busy  <= 1'b0;
`endif
                  end
               end
`ifdef REGENA_LOADER_PARITY_EN
               ST_PAR: begin
                  if (sin_sof) begin
                     frame_err <= 1'b1;
                     state     <= ST_SHIFT;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     // Even parity: data XOR parity bit must be zero.
                     if (parity == sin_data) begin
                        R   <= word;
                        ena <= 1'b1;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end
               end
`endif
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
